// File: rtl/prio_arbiter_rr.sv
// Registered N-input request arbiter with fixed-priority and round-robin modes.
// The grant is held until the owner asserts i_release.
module prio_arbiter_rr #(
  parameter int N      = 8,
  parameter int CODE_W = $clog2(N)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mode,
  input  logic [N-1:0]      i_req,
  input  logic              i_release,
  output logic [N-1:0]      o_grant,
  output logic [CODE_W-1:0] o_code,
  output logic              o_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [N-1:0]        r_grant;
  logic [CODE_W-1:0]   r_code;
  logic                r_valid;
  logic [CODE_W-1:0]   r_ptr;

  logic [CODE_W-1:0]   w_winFixed;
  logic [CODE_W-1:0]   w_winRr;
  logic [CODE_W-1:0]   w_win;
  logic                w_anyReq;
  logic [N-1:0]        w_grantNext;
  logic [CODE_W-1:0]   w_codeNext;
  logic                w_validNext;
  logic [CODE_W-1:0]   w_ptrNext;

  assign w_anyReq = |i_req;

  always_comb begin
    w_winFixed = '0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i]) w_winFixed = CODE_W'(i);
    end
  end

  // Scan from the farthest offset down so the closest request to r_ptr wins.
  always_comb begin
    w_winRr = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (i_req[idx]) w_winRr = CODE_W'(idx);
    end
  end

  assign w_win = i_mode ? w_winRr : w_winFixed;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyReq)  w_nextState = GRANT;
      GRANT:   if (i_release) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_grantNext = r_grant;
    w_codeNext  = r_code;
    w_validNext = r_valid;
    w_ptrNext   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_grantNext = {{(N-1){1'b0}}, 1'b1} << w_win;
          w_codeNext  = w_win;
          w_validNext = 1'b1;
          w_ptrNext   = (w_win == CODE_W'(N - 1)) ? '0 : w_win + 1'b1;
        end
      end
      GRANT: begin
        if (i_release) begin
          w_grantNext = '0;
          w_validNext = 1'b0;
        end
      end
      default: begin
        w_grantNext = '0;
        w_validNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_grant <= w_grantNext;
      r_code  <= w_codeNext;
      r_valid <= w_validNext;
      r_ptr   <= w_ptrNext;
    end
  end

  assign o_grant = r_grant;
  assign o_code  = r_code;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Self-checking bench for prio_arbiter_rr: vector table, corner sequences,
// randomized run against a behavioural model, plus an N=4 instance.
module tb_prio_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst, mode, rel;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] code;
  logic       valid;

  logic       rst4, mode4, rel4;
  logic [3:0] req4;
  logic [3:0] grant4;
  logic [1:0] code4;
  logic       valid4;

  int assertCount = 0;
  int errorCount  = 0;

  always #5 clk = ~clk;

  prio_arbiter_rr #(.N(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_req(req), .i_release(rel),
    .o_grant(grant), .o_code(code), .o_valid(valid)
  );

  prio_arbiter_rr #(.N(4)) dut4 (
    .i_clk(clk), .i_rst(rst4), .i_mode(mode4), .i_req(req4), .i_release(rel4),
    .o_grant(grant4), .o_code(code4), .o_valid(valid4)
  );

  typedef struct {
    logic       rst;
    logic       mode;
    logic [7:0] req;
    logic       rel;
    logic       expValid;
    logic [2:0] expCode;
    logic [7:0] expGrant;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  bit mValid;
  int mCode;
  int mPtr;

  task automatic addVec(input logic r, input logic m, input logic [7:0] q, input logic l,
                        input logic ev, input logic [2:0] ec, input logic [7:0] eg);
    vec_t v;
    v.rst = r; v.mode = m; v.req = q; v.rel = l;
    v.expValid = ev; v.expCode = ec; v.expGrant = eg;
    vecs.push_back(v);
  endtask

  // Drive inputs just after an edge, then advance one edge and settle before checking.
  task automatic applyStimulus(input logic r, input logic m, input logic [7:0] q, input logic l);
    rst = r; mode = m; req = q; rel = l;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [2:0] ec,
                             input logic [7:0] eg);
    assertCount++;
    if (valid !== ev) begin
      errorCount++;
      $display("[TB] FAIL %s valid: got %b expected %b", name, valid, ev);
    end
    assertCount++;
    if (code !== ec) begin
      errorCount++;
      $display("[TB] FAIL %s code: got %0d expected %0d", name, code, ec);
    end
    assertCount++;
    if (grant !== eg) begin
      errorCount++;
      $display("[TB] FAIL %s grant: got %h expected %h", name, grant, eg);
    end
    assertCount++;
    if (valid !== (|grant)) begin
      errorCount++;
      $display("[TB] FAIL %s invariant valid==|grant: valid %b grant %h", name, valid, grant);
    end
  endtask

  function automatic int fixedPick(input logic [7:0] q);
    for (int i = 7; i >= 0; i--) if (q[i]) return i;
    return -1;
  endfunction

  function automatic int rrPick(input logic [7:0] q, input int p);
    for (int k = 0; k < 8; k++) if (q[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic modelStep(input logic r, input logic m, input logic [7:0] q, input logic l);
    int w;
    if (r) begin
      mValid = 0; mCode = 0; mPtr = 0;
    end else if (mValid) begin
      if (l) mValid = 0;
    end else if (q != 0) begin
      w = m ? rrPick(q, mPtr) : fixedPick(q);
      mValid = 1; mCode = w; mPtr = (w + 1) % 8;
    end
  endtask

  initial begin
    rst = 1; mode = 0; req = '0; rel = 0;
    rst4 = 1; mode4 = 0; req4 = '0; rel4 = 0;

    // Reset, fixed priority, hold, release, idle, reset mid-grant, release+request
    addVec(1, 0, 8'h00, 0, 0, 3'd0, 8'h00);
    addVec(0, 0, 8'hA4, 0, 1, 3'd7, 8'h80);
    addVec(0, 0, 8'hA4, 1, 0, 3'd7, 8'h00);
    addVec(0, 0, 8'h00, 0, 0, 3'd7, 8'h00);
    addVec(0, 0, 8'h00, 1, 0, 3'd7, 8'h00);
    addVec(0, 0, 8'h08, 0, 1, 3'd3, 8'h08);
    addVec(0, 0, 8'h00, 0, 1, 3'd3, 8'h08);
    addVec(0, 1, 8'h00, 0, 1, 3'd3, 8'h08);
    addVec(0, 0, 8'h00, 0, 1, 3'd3, 8'h08);
    addVec(0, 1, 8'h00, 0, 1, 3'd3, 8'h08);
    addVec(0, 0, 8'h00, 0, 1, 3'd3, 8'h08);
    addVec(0, 0, 8'hFF, 1, 0, 3'd3, 8'h00);
    addVec(0, 0, 8'h10, 0, 1, 3'd4, 8'h10);
    addVec(1, 1, 8'hFF, 0, 0, 3'd0, 8'h00);
    addVec(0, 1, 8'hFF, 0, 1, 3'd0, 8'h01);
    addVec(0, 1, 8'hFF, 1, 0, 3'd0, 8'h00);
    addVec(0, 1, 8'hFF, 0, 1, 3'd1, 8'h02);
    addVec(0, 0, 8'h80, 0, 1, 3'd1, 8'h02);
    addVec(0, 0, 8'h80, 1, 0, 3'd1, 8'h00);
    addVec(0, 0, 8'h80, 0, 1, 3'd7, 8'h80);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].mode, vecs[i].req, vecs[i].rel);
      checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expCode, vecs[i].expGrant);
    end

    // Round-robin sweep with all requests held, one idle cycle between grants
    applyStimulus(1, 1, 8'h00, 0);
    checkOutput("rrReset", 0, 3'd0, 8'h00);
    for (int k = 0; k < 9; k++) begin
      logic [7:0] g;
      logic [2:0] c;
      c = 3'(k % 8);
      g = 8'h01 << c;
      applyStimulus(0, 1, 8'hFF, 0);
      checkOutput($sformatf("rrGrant%0d", k), 1, c, g);
      applyStimulus(0, 1, 8'hFF, 1);
      checkOutput($sformatf("rrIdle%0d", k), 0, c, 8'h00);
    end

    // Round-robin wrap: grant 5 in fixed mode, then ptr=6 scans 6,7,0
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 0, 8'h20, 0);
    checkOutput("wrapSeed", 1, 3'd5, 8'h20);
    applyStimulus(0, 0, 8'h00, 1);
    applyStimulus(0, 1, 8'h03, 0);
    checkOutput("wrapFirst", 1, 3'd0, 8'h01);
    applyStimulus(0, 1, 8'h03, 1);
    applyStimulus(0, 1, 8'h03, 0);
    checkOutput("wrapSecond", 1, 3'd1, 8'h02);

    // Idle with release toggling
    applyStimulus(0, 1, 8'h00, 1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 1, 8'h00, k[0]);
      checkOutput($sformatf("idleToggle%0d", k), 0, 3'd1, 8'h00);
    end

    // Randomized run against the behavioural model
    applyStimulus(1, 0, 8'h00, 0);
    modelStep(1, 0, 8'h00, 0);
    for (int k = 0; k < 600; k++) begin
      logic r, m, l;
      logic [7:0] q;
      r = ($urandom_range(0, 31) == 0);
      m = 1'($urandom_range(0, 1));
      l = ($urandom_range(0, 2) == 0);
      q = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      applyStimulus(r, m, q, l);
      modelStep(r, m, q, l);
      checkOutput($sformatf("rand%0d", k), mValid, 3'(mCode),
                  mValid ? (8'h01 << mCode) : 8'h00);
    end

    // N=4 instance: fixed priority picks index 2 of 4'b0110
    rst4 = 1; @(posedge clk); #1;
    assertCount++;
    if (valid4 !== 1'b0 || grant4 !== 4'h0 || code4 !== 2'd0) begin
      errorCount++;
      $display("[TB] FAIL n4Reset: got valid %b code %0d grant %h expected 0 0 0", valid4, code4, grant4);
    end
    rst4 = 0; mode4 = 0; req4 = 4'b0110; @(posedge clk); #1;
    assertCount++;
    if (valid4 !== 1'b1 || code4 !== 2'd2 || grant4 !== 4'h4) begin
      errorCount++;
      $display("[TB] FAIL n4Grant: got valid %b code %0d grant %h expected 1 2 4", valid4, code4, grant4);
    end
    rel4 = 1; @(posedge clk); #1;
    assertCount++;
    if (valid4 !== 1'b0 || grant4 !== 4'h0) begin
      errorCount++;
      $display("[TB] FAIL n4Release: got valid %b grant %h expected 0 0", valid4, grant4);
    end
    rel4 = 0; mode4 = 1; req4 = 4'b1001; @(posedge clk); #1;
    assertCount++;
    if (valid4 !== 1'b1 || code4 !== 2'd3 || grant4 !== 4'h8) begin
      errorCount++;
      $display("[TB] FAIL n4RoundRobin: got valid %b code %0d grant %h expected 1 3 8", valid4, code4, grant4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, errorCount);
    $finish;
  end

endmodule
